// File: rtl/clock_tap_monitor.sv
// clock_tap_monitor: pipelined one-hot tap encoder, legality check and settle FSM for the delay-line tap bus.
// Define CLOCK_TAP_HIST_EN to build tap_min/tap_max/move_cnt history; otherwise those outputs are tied to 0.
module clock_tap_monitor #(
  parameter int WIDTH         = 512,
  parameter int TAP_W         = 9,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] en,
  input  logic [2:0]       status,
  input  logic             clear,
  output logic [TAP_W-1:0] tap,
  output logic             tap_valid,
  output logic             onehot_err,
  output logic             settled,
  output logic             at_limit,
  output logic [TAP_W-1:0] tap_min,
  output logic [TAP_W-1:0] tap_max,
  output logic [CNT_W-1:0] move_cnt
);
  localparam int G = WIDTH / 32;
  localparam int GW = TAP_W - 5;
  localparam logic [31:0] DWELL_END = 32'(STABLE_CYCLES - 1);
  typedef enum logic [1:0] {WAIT_LOCK, TRACK, SETTLED} state_t;
  state_t state, state_nxt;
  logic [4:0] g_idx [G];
  logic [1:0] g_cnt [G];
  logic [4:0] s1_idx [G];
  logic [1:0] s1_cnt [G];
  logic [1:0] s1_st;
  logic [TAP_W-1:0] sel;
  logic [2:0] sum;
  logic legal, lock, moved, have_tap, stable, unused_top;
  logic [CNT_W-1:0] dwell, dwell_nxt;
  assign unused_top = status[0];
  always_comb begin
    for (int g = 0; g < G; g++) begin
      g_idx[g] = '0;
      g_cnt[g] = '0;
      for (int b = 0; b < 32; b++)
        if (en[g*32+b]) begin
          g_idx[g] = g_idx[g] | 5'(b);
          g_cnt[g] = (g_cnt[g] == 2'd0) ? 2'd1 : 2'd2;
        end
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int g = 0; g < G; g++) begin
        s1_idx[g] <= '0;
        s1_cnt[g] <= '0;
      end
      s1_st <= '0;
    end else begin
      s1_idx <= g_idx;
      s1_cnt <= g_cnt;
      s1_st <= status[2:1];
    end
  always_comb begin
    sel = '0;
    sum = '0;
    for (int g = 0; g < G; g++) begin
      sel = sel | ((s1_cnt[g] != 2'd0) ? {GW'(g), s1_idx[g]} : '0);
      sum = ((sum + {1'b0, s1_cnt[g]}) > 3'd2) ? 3'd2 : sum + {1'b0, s1_cnt[g]};
    end
    legal = (sum == 3'd1);
  end
  // A move needs an earlier legal tap; the reset value of tap is not one.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      tap <= TAP_W'(WIDTH - 1);
      tap_valid <= 1'b0;
      onehot_err <= 1'b0;
      at_limit <= 1'b0;
      lock <= 1'b0;
      moved <= 1'b0;
      have_tap <= 1'b0;
    end else begin
      tap_valid <= legal;
      onehot_err <= !clear && (onehot_err || !legal);
      at_limit <= s1_st[0];
      lock <= s1_st[1];
      moved <= legal && have_tap && (sel != tap);
      if (legal) begin
        tap <= sel;
        have_tap <= 1'b1;
      end
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= WAIT_LOCK;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      dwell <= dwell_nxt;
    end
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    stable = tap_valid && !moved;
    if (clear || !lock) begin
      state_nxt = WAIT_LOCK;
      dwell_nxt = '0;
    end else if (state == WAIT_LOCK) begin
      state_nxt = tap_valid ? TRACK : WAIT_LOCK;
      dwell_nxt = '0;
    end else if (!stable) begin
      state_nxt = TRACK;
      dwell_nxt = '0;
    end else if (state == TRACK) begin
      if (32'(dwell) == DWELL_END) state_nxt = SETTLED;
      else if (dwell != '1) dwell_nxt = dwell + 1'b1;
    end
  end
  assign settled = (state == SETTLED);
`ifdef CLOCK_TAP_HIST_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      tap_min <= '1;
      tap_max <= '0;
      move_cnt <= '0;
    end else if (clear) begin
      tap_min <= '1;
      tap_max <= '0;
      move_cnt <= '0;
    end else if (tap_valid) begin
      if (tap < tap_min) tap_min <= tap;
      if (tap > tap_max) tap_max <= tap;
      if (moved && move_cnt != '1) move_cnt <= move_cnt + 1'b1;
    end
`else
  assign tap_min = '0;
  assign tap_max = '0;
  assign move_cnt = '0;
`endif
endmodule

// File: tb/tb_clock_tap_monitor.sv
// tb_clock_tap_monitor: directed checks of encode latency, legality, settle timing, history and reset/clear.
module tb_clock_tap_monitor;
  logic clk = 1'b0;
  logic resetn, clear;
  logic [511:0] en;
  logic [2:0] status;
  logic [8:0] tap, tap_min, tap_max;
  logic tap_valid, onehot_err, settled, at_limit;
  logic [15:0] move_cnt;
  int tests = 0;
  int fails = 0;
  int n;
`ifdef CLOCK_TAP_HIST_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif
  always #5 clk = ~clk;
  clock_tap_monitor dut (
    .clk(clk), .resetn(resetn), .en(en), .status(status), .clear(clear),
    .tap(tap), .tap_valid(tap_valid), .onehot_err(onehot_err), .settled(settled),
    .at_limit(at_limit), .tap_min(tap_min), .tap_max(tap_max), .move_cnt(move_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic hist(input string tag, input int mn, input int mx, input int mc);
    chk({tag, "_min"}, 32'(tap_min), HIST ? 32'(mn) : 32'd0);
    chk({tag, "_max"}, 32'(tap_max), HIST ? 32'(mx) : 32'd0);
    chk({tag, "_moves"}, 32'(move_cnt), HIST ? 32'(mc) : 32'd0);
  endtask
  function automatic logic [511:0] oh(input int i);
    logic [511:0] one = 512'd1;
    return one << i;
  endfunction
  initial begin
    resetn = 1'b1;
    clear = 1'b0;
    en = oh(511);
    status = 3'b011;
    #2 resetn = 1'b0;
    #2;
    chk("rst_tap", 32'(tap), 511);
    chk("rst_valid", 32'(tap_valid), 0);
    chk("rst_err", 32'(onehot_err), 0);
    chk("rst_settled", 32'(settled), 0);
    chk("rst_limit", 32'(at_limit), 0);
    hist("rst", 511, 0, 0);
    step(1);
    resetn = 1'b1;
    step(1);
    chk("t1_valid_c1", 32'(tap_valid), 0);
    step(1);
    chk("t1_tap", 32'(tap), 511);
    chk("t1_valid", 32'(tap_valid), 1);
    chk("t1_limit", 32'(at_limit), 1);
    step(3);
    chk("t1_settled", 32'(settled), 0);
    resetn = 1'b0;
    en = oh(200);
    status = 3'b100;
    step(1);
    resetn = 1'b1;
    n = 0;
    while (!settled && n < 1100) begin
      step(1);
      n++;
    end
    chk("t2_latency", 32'(n), 1027);
    chk("t2_tap", 32'(tap), 200);
    hist("t2", 200, 200, 0);
    en = oh(201);
    step(2);
    chk("t3_settled_hold", 32'(settled), 1);
    step(1);
    chk("t3_settled_fall", 32'(settled), 0);
    chk("t3_tap", 32'(tap), 201);
    hist("t3", 200, 201, 1);
    en = '0;
    step(1);
    en = oh(5) | oh(300);
    step(1);
    chk("t4_valid_zero", 32'(tap_valid), 0);
    chk("t4_tap_zero", 32'(tap), 201);
    chk("t4_err", 32'(onehot_err), 1);
    en = oh(201);
    step(1);
    chk("t4_valid_two", 32'(tap_valid), 0);
    chk("t4_tap_two", 32'(tap), 201);
    step(1);
    chk("t4_valid_back", 32'(tap_valid), 1);
    step(5);
    chk("t4_err_sticky", 32'(onehot_err), 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t4_err_clear", 32'(onehot_err), 0);
    chk("t4_valid_kept", 32'(tap_valid), 1);
    chk("t4_settled", 32'(settled), 0);
    hist("t4", 511, 0, 0);
    en = oh(0);
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    for (int i = 0; i < 512; i++) begin
      en = oh(i);
      step(1);
      if (i > 0) chk($sformatf("t5_sweep%0d", i - 1), 32'(tap), 32'(i - 1));
    end
    step(1);
    chk("t5_sweep511", 32'(tap), 511);
    step(2);
    hist("t5", 0, 511, 511);
    en = oh(100);
    status = 3'b100;
    step(50);
    chk("t6_mid_dwell", 32'(settled), 0);
    resetn = 1'b0;
    #2;
    chk("t6_rst_tap", 32'(tap), 511);
    chk("t6_rst_valid", 32'(tap_valid), 0);
    chk("t6_rst_err", 32'(onehot_err), 0);
    chk("t6_rst_limit", 32'(at_limit), 0);
    hist("t6_rst", 511, 0, 0);
    step(1);
    resetn = 1'b1;
    step(1);
    chk("t6_valid_c1", 32'(tap_valid), 0);
    step(1);
    chk("t6_tap", 32'(tap), 100);
    chk("t6_valid", 32'(tap_valid), 1);
    en = oh(101);
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t6_clear_valid", 32'(tap_valid), 1);
    chk("t6_clear_tap", 32'(tap), 101);
    hist("t6_clear", 511, 0, 0);
    step(1);
    hist("t6_after", 101, 101, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
